alu_op_sequencer: RTL and testbench

- Initiator side of the ALU4Bit operand/result interface.
- Accepts operation requests over a valid/ready handshake and drives registered a/b/op to an external ALU4Bit.
- Captures result and flags one cycle later and returns them over a valid/ready response channel.
- Keeps an operation counter and an overflow counter for bench and debug visibility.

---
 rtl/alu_seq_pkg.sv | 22 ++
 rtl/alu_seq_refmodel.sv | 29 ++
 rtl/alu_op_sequencer.sv | 130 +++++++++++++
 tb/tb_alu_op_sequencer.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared constants for the ALU operation sequencer: op codes, FSM encoding
// and bit positions inside rsp_flags.
package alu_seq_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_ANDN = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // rsp_flags = {cout, overflow, zero, set}
  localparam int FLAG_COUT = 3;
  localparam int FLAG_OVF  = 2;
  localparam int FLAG_ZERO = 1;
  localparam int FLAG_SET  = 0;

endpackage

// File: rtl/alu_seq_refmodel.sv
// Combinational expected-result model for the op codes with a defined
// meaning; reserved codes 011 and 101 report checked=0.
module alu_seq_refmodel
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] expected,
  output logic             checked
);

  always_comb begin
    expected = '0;
    checked  = 1'b1;
    case (op)
      OP_AND:  expected = a & b;
      OP_OR:   expected = a | b;
      OP_ADD:  expected = a + b;
      OP_ANDN: expected = a & ~b;
      OP_SUB:  expected = a - b;
      OP_SLT:  expected = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: checked  = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Initiator for an external ALU4Bit: registers a request, captures the ALU
// result one cycle later and returns it. Optional checker: ALU_SEQ_SELFCHECK_EN.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [2:0]       req_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout,
  input  logic             alu_overflow,
  input  logic             alu_zero,
  input  logic             alu_set,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_flags,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] ovf_count,
`ifdef ALU_SEQ_SELFCHECK_EN
  output logic             rsp_mismatch,
  output logic             err_sticky,
`endif
  output logic [1:0]       dbg_state
);

  logic [1:0] state;
  logic       accept;
  logic [3:0] flags_in;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never drops and its payload never changes until then.
  assign req_ready = (state == ST_IDLE) || ((state == ST_RESP) && rsp_ready);
  assign accept    = req_valid && req_ready;
  assign dbg_state = state;

  always_comb begin
    flags_in            = '0;
    flags_in[FLAG_COUT] = alu_cout;
    flags_in[FLAG_OVF]  = alu_overflow;
    flags_in[FLAG_ZERO] = alu_zero;
    flags_in[FLAG_SET]  = alu_set;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      op_count   <= '0;
      ovf_count  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            alu_a  <= req_a;
            alu_b  <= req_b;
            alu_op <= req_op;
            state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_result <= alu_result;
          rsp_flags  <= flags_in;
          rsp_valid  <= 1'b1;
          op_count   <= op_count + CNT_W'(1);
          if (alu_overflow && (ovf_count != {CNT_W{1'b1}}))
            ovf_count <= ovf_count + CNT_W'(1);
          state <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (accept) begin
              alu_a  <= req_a;
              alu_b  <= req_b;
              alu_op <= req_op;
              state  <= ST_EXEC;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ALU_SEQ_SELFCHECK_EN
  logic [WIDTH-1:0] ref_result;
  logic             ref_checked;
  logic             mismatch_now;

  alu_seq_refmodel #(.WIDTH(WIDTH)) u_refmodel (
    .a        (alu_a),
    .b        (alu_b),
    .op       (alu_op),
    .expected (ref_result),
    .checked  (ref_checked)
  );

  assign mismatch_now = ref_checked && (ref_result != alu_result);

  // Captured on the same edge as rsp_result so the two always describe one op.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_mismatch <= 1'b0;
      err_sticky   <= 1'b0;
    end else if (state == ST_EXEC) begin
      rsp_mismatch <= mismatch_now;
      err_sticky   <= err_sticky | mismatch_now;
    end
  end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural ALU, randomized requests, and a
// queue-based response scoreboard with cycle-level handshake expectations.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  localparam int W  = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          rsp_ready = 1'b0;
  logic [W-1:0]  req_a = '0;
  logic [W-1:0]  req_b = '0;
  logic [2:0]    req_op = '0;
  logic          req_ready;
  logic [W-1:0]  alu_a, alu_b;
  logic [2:0]    alu_op;
  logic [W-1:0]  alu_result;
  logic          alu_cout, alu_overflow, alu_zero, alu_set;
  logic          rsp_valid;
  logic [W-1:0]  rsp_result;
  logic [3:0]    rsp_flags;
  logic [CW-1:0] op_count, ovf_count;
  logic [1:0]    dbg_state;
`ifdef ALU_SEQ_SELFCHECK_EN
  logic          rsp_mismatch, err_sticky;
`endif

  logic corrupt = 1'b0;
  bit   rand_bp = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  alu_op_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_op       (req_op),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_result   (alu_result),
    .alu_cout     (alu_cout),
    .alu_overflow (alu_overflow),
    .alu_zero     (alu_zero),
    .alu_set      (alu_set),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_flags    (rsp_flags),
    .op_count     (op_count),
    .ovf_count    (ovf_count),
`ifdef ALU_SEQ_SELFCHECK_EN
    .rsp_mismatch (rsp_mismatch),
    .err_sticky   (err_sticky),
`endif
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Behavioural 4-bit ALU: returns {cout, overflow, zero, set, result}.
  function automatic logic [7:0] alu_eval(input logic [3:0] a, input logic [3:0] b,
                                          input logic [2:0] op);
    logic [3:0] bb, r;
    int cin, usum, ssum, sa, sb;
    logic co, ov, lt;
    bb   = op[2] ? ~b : b;
    cin  = op[2] ? 1 : 0;
    usum = int'(a) + int'(bb) + cin;
    sa   = int'(a) - (a[3] ? 16 : 0);
    sb   = int'(bb) - (bb[3] ? 16 : 0);
    ssum = sa + sb + cin;
    co   = usum > 15;
    ov   = (ssum > 7) || (ssum < -8);
    lt   = ssum < 0;
    case (op[1:0])
      2'b00:   r = a & bb;
      2'b01:   r = a | bb;
      2'b10:   r = 4'(usum);
      default: r = {3'b000, lt};
    endcase
    return {co, ov, (r == 4'd0), lt, r};
  endfunction

  function automatic bit op_checked(input logic [2:0] op);
    return (op != 3'b011) && (op != 3'b101);
  endfunction

  logic [7:0] alu_e;
  always_comb begin
    alu_e      = alu_eval(alu_a, alu_b, alu_op);
    alu_result = alu_e[3:0] ^ {3'b000, corrupt};
    {alu_cout, alu_overflow, alu_zero, alu_set} = alu_e[7:4];
  end

  // ---------------- scoreboard / monitor ----------------
  logic [W+4:0] exp_q[$];
  bit           inflight = 0;
  bit           held = 0;
  int           acc_cyc = 0;
  logic [W-1:0] acc_a, acc_b;
  logic [2:0]   acc_op;
  int           ops_total = 0, ovf_total = 0;
  bit           err_m = 0;
  int           hs_count = 0, last_hs = 0, prev_hs = 0, last_lat = 0;
  logic [W-1:0] last_result = '0, prev_result = '0, held_result;
  logic [3:0]   last_flags = '0, held_flags;
  logic         last_mm = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      inflight  = 0;
      held      = 0;
      ops_total = 0;
      ovf_total = 0;
      err_m     = 0;
    end else begin
      bit vis, rr_exp;
      logic [W+4:0] e;
      logic [7:0]   r;
      vis    = inflight && (cyc - acc_cyc >= 2);
      rr_exp = !inflight || (vis && rsp_ready);
      check_eq("rsp_valid", rsp_valid, vis);
      check_eq("req_ready", req_ready, rr_exp);
      if (inflight && (cyc - acc_cyc == 1)) begin
        check_eq("alu_a", alu_a, acc_a);
        check_eq("alu_b", alu_b, acc_b);
        check_eq("alu_op", alu_op, acc_op);
      end
      if (vis && held) begin
        check_eq("rsp_hold_result", rsp_result, held_result);
        check_eq("rsp_hold_flags", rsp_flags, held_flags);
      end
      held        = vis && !rsp_ready;
      held_result = rsp_result;
      held_flags  = rsp_flags;
      if (vis && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("exp_q_size", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          ops_total++;
          if (e[W+2]) ovf_total++;
          if (e[W+4]) err_m = 1;
          check_eq("rsp_result", rsp_result, e[W-1:0]);
          check_eq("rsp_flags", rsp_flags, e[W+3:W]);
          check_eq("op_count", op_count, ops_total % (1 << CW));
          check_eq("ovf_count", ovf_count, (ovf_total > 255) ? 255 : ovf_total);
`ifdef ALU_SEQ_SELFCHECK_EN
          check_eq("rsp_mismatch", rsp_mismatch, e[W+4]);
          check_eq("err_sticky", err_sticky, err_m);
          last_mm = rsp_mismatch;
`endif
        end
        prev_result = last_result;
        last_result = rsp_result;
        last_flags  = rsp_flags;
        prev_hs     = last_hs;
        last_hs     = cyc;
        last_lat    = cyc - acc_cyc;
        hs_count++;
        inflight = 0;
      end
      if (req_valid && rr_exp) begin
        r = alu_eval(req_a, req_b, req_op);
        exp_q.push_back({corrupt && op_checked(req_op), r[7:4], r[3:0] ^ {3'b000, corrupt}});
        inflight = 1;
        acc_cyc  = cyc;
        acc_a    = req_a;
        acc_b    = req_b;
        acc_op   = req_op;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    if (rand_bp) rsp_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send_req(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    bit got;
    req_a     = a;
    req_b     = b;
    req_op    = op;
    req_valid = 1'b1;
    got       = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (req_ready) got = 1;
      step();
    end
    req_valid = 1'b0;
    check_eq("req_accept", got, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && inflight; i++) step();
    check_eq("drain", inflight, 0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic send_random();
    send_req(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
  endtask

  // ---------------- stimulus ----------------
  int hs_before;

  initial begin
    repeat (3) step();
    reset = 1'b0;
    check_eq("reset_state", dbg_state, ST_IDLE);
    check_eq("reset_req_ready", req_ready, 1);
    check_eq("reset_rsp_valid", rsp_valid, 0);
    check_eq("reset_rsp_result", rsp_result, 0);
    check_eq("reset_rsp_flags", rsp_flags, 0);
    check_eq("reset_op_count", op_count, 0);
    check_eq("reset_ovf_count", ovf_count, 0);
    check_eq("reset_alu_abop", {alu_a, alu_b, 1'b0, alu_op}, 0);

    // ADD with signed overflow
    rsp_ready = 1'b1;
    send_req(4'b0111, 4'b0111, 3'b010);
    wait_idle();
    check_eq("add_result", last_result, 4'b1110);
    check_eq("add_ovf", last_flags[FLAG_OVF], 1);
    check_eq("add_cout", last_flags[FLAG_COUT], 0);
    check_eq("add_latency", last_lat, 2);
    check_eq("add_op_count", op_count, 1);
    check_eq("add_ovf_count", ovf_count, 1);

    // SUB to zero
    send_req(4'b0111, 4'b0111, 3'b110);
    wait_idle();
    check_eq("sub_result", last_result, 4'b0000);
    check_eq("sub_zero", last_flags[FLAG_ZERO], 1);
    check_eq("sub_ovf", last_flags[FLAG_OVF], 0);

    // SLT back-to-back
    send_req(4'b1001, 4'b1111, 3'b111);
    send_req(4'b1111, 4'b1001, 3'b111);
    wait_idle();
    check_eq("slt_first", prev_result, 4'b0001);
    check_eq("slt_second", last_result, 4'b0000);
    check_eq("slt_spacing", last_hs - prev_hs, 2);

    // Backpressure
    rsp_ready = 1'b0;
    hs_before = hs_count;
    send_req(4'b1000, 4'b1000, 3'b010);
    repeat (6) step();
    check_eq("bp_valid", rsp_valid, 1);
    check_eq("bp_result", rsp_result, 4'b0000);
    check_eq("bp_cout", rsp_flags[FLAG_COUT], 1);
    check_eq("bp_ovf", rsp_flags[FLAG_OVF], 1);
    check_eq("bp_req_ready", req_ready, 0);
    check_eq("bp_no_hs", hs_count - hs_before, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    repeat (3) step();
    check_eq("bp_one_hs", hs_count - hs_before, 1);
    check_eq("bp_released", rsp_valid, 0);

    // Reset during EXEC and during RESP
    rsp_ready = 1'b1;
    send_req(4'b0111, 4'b0111, 3'b010);
    check_eq("rst_in_exec", dbg_state, ST_EXEC);
    pulse_reset();
    check_eq("rst_exec_valid", rsp_valid, 0);
    check_eq("rst_exec_state", dbg_state, ST_IDLE);
    check_eq("rst_exec_op_count", op_count, 0);
    step();
    check_eq("rst_exec_valid2", rsp_valid, 0);
    check_eq("rst_exec_ready", req_ready, 1);
    rsp_ready = 1'b0;
    send_req(4'b0011, 4'b0001, 3'b010);
    step();
    check_eq("rst_in_resp", rsp_valid, 1);
    pulse_reset();
    check_eq("rst_resp_valid", rsp_valid, 0);
    check_eq("rst_resp_state", dbg_state, ST_IDLE);
    rsp_ready = 1'b1;

    // op_count wrap: 257 ops
    pulse_reset();
    for (int i = 0; i < 257; i++) send_random();
    wait_idle();
    check_eq("wrap_op_count", op_count, 1);

    // ovf_count saturation: 260 overflowing adds
    pulse_reset();
    for (int i = 0; i < 260; i++) send_req(4'b0111, 4'b0111, 3'b010);
    wait_idle();
    check_eq("sat_ovf_count", ovf_count, 255);
    check_eq("sat_op_count", op_count, 4);

    // Random traffic with random backpressure and idle gaps
    rand_bp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send_random();
      repeat ($urandom_range(0, 2)) step();
    end
    rand_bp   = 1'b0;
    rsp_ready = 1'b1;
    wait_idle();

`ifdef ALU_SEQ_SELFCHECK_EN
    pulse_reset();
    corrupt = 1'b1;
    send_req(4'b0011, 4'b0100, 3'b010);
    wait_idle();
    corrupt = 1'b0;
    check_eq("sc_mismatch", last_mm, 1);
    check_eq("sc_sticky", err_sticky, 1);
    send_req(4'b0101, 4'b0011, 3'b110);
    send_req(4'b1100, 4'b1010, 3'b000);
    wait_idle();
    check_eq("sc_mismatch_clear", last_mm, 0);
    check_eq("sc_sticky_held", err_sticky, 1);
    pulse_reset();
    check_eq("sc_sticky_reset", err_sticky, 0);
`endif

    repeat (2) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
